step_counter_gen: RTL and testbench
===================================

# step_counter_gen

Parametrised up/down step counter, successor to the fixed 0..9 step counter. Counts in the range 0..MAX_VAL with a run-time step size, a selectable saturate-or-wrap policy, synchronous parallel load and registered status/event flags. Control inputs pass through one registered stage, as in the existing counter. All logic runs on a single rising clock edge; there is no negedge logic.

## Interface
- WIDTH, 4: counter width; MAX_VAL must satisfy MAX_VAL < 2**WIDTH.
- MAX_VAL, 9: upper bound of the count range.
- STEP_W, 3: step input width; elaboration-time check requires 2**STEP_W-1 <= MAX_VAL.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  synchronous reset, active-high; acts directly and is not delayed by the input stage.
- En  in  1  count enable.
- Mode  in  1  1 = count up, 0 = count down.
- Wrap  in  1  0 = hold on overshoot, 1 = modulo (MAX_VAL+1) wrap.
- Step  in  STEP_W  step size; 0 = no change.
- Load  in  1  parallel load request.
- LoadVal  in  WIDTH  load value.
- Cnt  out  WIDTH  current count, registered.
- AtMax  out  1  Cnt == MAX_VAL, decoded from the Cnt register.
- AtMin  out  1  Cnt == 0, decoded from the Cnt register.
- Wrapped  out  1  one-cycle pulse, registered: the last update wrapped.
- Blocked  out  1  one-cycle pulse, registered: the last update was refused because of overshoot.

## Operation
- Input stage: En, Mode, Wrap, Step, Load and LoadVal are registered each edge into b_* copies. The update logic uses only the b_* copies.
- Update priority on each edge: Rst, then b_load, then b_en, otherwise hold.
- Rst: Cnt=0, all b_* copies cleared, Wrapped=0, Blocked=0.
- Load: Cnt = min(b_loadval, MAX_VAL). Wrapped and Blocked are 0.
- Count up, target t = Cnt + b_step, computed in WIDTH+1 bits:
  - t <= MAX_VAL: Cnt = t.
  - t > MAX_VAL with b_wrap=1: Cnt = t - (MAX_VAL+1) and Wrapped=1.
  - t > MAX_VAL with b_wrap=0: Cnt holds; Blocked=1. There is no partial clamp; this matches the existing hold-on-overshoot behaviour.
- Count down, mirror of up:
  - Cnt >= b_step: Cnt = Cnt - b_step.
  - Otherwise with b_wrap=1: Cnt = Cnt + (MAX_VAL+1) - b_step and Wrapped=1.
  - Otherwise with b_wrap=0: Cnt holds; Blocked=1.
- b_step=0 with b_en=1: Cnt holds; Wrapped=0 and Blocked=0.
- Wrapped and Blocked are 0 on any edge that does not raise them. They are never both 1.

## Timing
- Control latency: a change on En, Mode, Wrap, Step, Load or LoadVal sampled at edge N affects Cnt at edge N+1.
- Rst sampled high at edge N gives Cnt=0 after edge N. Rst mid-count overrides a pending load or step.
- First edge after Rst deasserts: the b_* copies are still cleared, so Cnt holds at 0.
- Reset values: Cnt=0, AtMin=1, AtMax=0, Wrapped=0, Blocked=0.
- AtMax and AtMin are valid in the same cycle as Cnt. Wrapped and Blocked are valid in the same cycle as the Cnt they describe.
- Throughput: one update per clock. Flags carry no state between updates.

## Structure
- Package counter_pkg holds:
  - Mode encoding constants MODE_DOWN=0 and MODE_UP=1.
  - Policy constants WRAP_HOLD=0 and WRAP_MOD=1.
  - The elaboration check function for the parameter constraints.
- Sub-module step_counter_next: purely combinational. Inputs are Cnt, b_mode, b_wrap and b_step; outputs are next count, wrap and block. The top level keeps the input stage, priority mux and flag registers.

## Test plan
- Defaults. Rst, then En=1, Mode=1, Wrap=0, Step=1 for 12 edges -> Cnt steps 0..9, then holds at 9 with Blocked pulsing each edge and AtMax=1.
- Step=3, Mode=1, Wrap=0 from Cnt=7 -> Cnt holds at 7 with Blocked=1; from Cnt=6 -> Cnt=9 with Blocked=0.
- Wrap=1, Mode=1, Step=3 from Cnt=8 -> Cnt=1 with Wrapped=1 for one cycle. Then Mode=0, Step=2 from Cnt=1 -> Cnt=9 with Wrapped=1.
- Load=1, LoadVal=15 -> Cnt=9 (clamped) two edges after Load is asserted. Load and En together -> load wins.
- Rst asserted mid-count at Cnt=5 together with Load=1, LoadVal=2 -> Cnt=0 on that edge. Cnt stays 0 on the first edge after Rst deasserts.
- Parameters WIDTH=8, MAX_VAL=199, STEP_W=4. Up with Wrap=1, Step=15 from Cnt=190 -> Cnt=5. Down with Wrap=0, Step=15 from Cnt=10 -> Cnt holds with Blocked=1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings and parameter sanity check for the step counter family.
package counter_pkg;

  typedef enum logic {
    MODE_DOWN = 1'b0,
    MODE_UP   = 1'b1
  } mode_e;

  typedef enum logic {
    WRAP_HOLD = 1'b0,
    WRAP_MOD  = 1'b1
  } wrap_e;

  // Count range must fit the register, and the largest step must fit the range.
  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned max_val,
                                   input int unsigned step_w);
    if (width < 1 || width > 30 || step_w < 1 || step_w > 30) return 1'b0;
    return (max_val < (32'd1 << width)) && (((32'd1 << step_w) - 32'd1) <= max_val);
  endfunction

endpackage

// File: rtl/step_counter_next.sv
// Combinational next-count calculation for one step, including wrap/block decisions.
module step_counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = 9,
  parameter int unsigned STEP_W  = 3
) (
  input  logic [WIDTH-1:0]  cnt,
  input  logic              b_mode,
  input  logic              b_wrap,
  input  logic [STEP_W-1:0] b_step,
  output logic [WIDTH-1:0]  nxt_cnt,
  output logic              nxt_wrap,
  output logic              nxt_block
);

  localparam logic [WIDTH:0] MAX_EXT   = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] RANGE_EXT = (WIDTH+1)'(MAX_VAL + 1);

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    cnt_ext   = {1'b0, cnt};
    step_ext  = {{(WIDTH+1-STEP_W){1'b0}}, b_step};
    sum       = '0;
    diff      = '0;
    nxt_cnt   = cnt;
    nxt_wrap  = 1'b0;
    nxt_block = 1'b0;
    if (b_mode == MODE_UP) begin
      sum = cnt_ext + step_ext;
      if (sum <= MAX_EXT) begin
        nxt_cnt = sum[WIDTH-1:0];
      end else if (b_wrap == WRAP_MOD) begin
        diff     = sum - RANGE_EXT;
        nxt_cnt  = diff[WIDTH-1:0];
        nxt_wrap = 1'b1;
      end else begin
        nxt_block = 1'b1;
      end
    end else begin
      if (cnt_ext >= step_ext) begin
        diff    = cnt_ext - step_ext;
        nxt_cnt = diff[WIDTH-1:0];
      end else if (b_wrap == WRAP_MOD) begin
        // cnt + MAX_VAL + 1 stays below 2**(WIDTH+1), so WIDTH+1 bits suffice.
        diff     = cnt_ext + RANGE_EXT - step_ext;
        nxt_cnt  = diff[WIDTH-1:0];
        nxt_wrap = 1'b1;
      end else begin
        nxt_block = 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_counter_gen.sv
// Up/down step counter over 0..MAX_VAL with registered control inputs,
// parallel load with clamp, and registered wrap/block event pulses.
module step_counter_gen
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_VAL = 9,
  parameter int unsigned STEP_W  = 3
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic              Mode,
  input  logic              Wrap,
  input  logic [STEP_W-1:0] Step,
  input  logic              Load,
  input  logic [WIDTH-1:0]  LoadVal,
  output logic [WIDTH-1:0]  Cnt,
  output logic              AtMax,
  output logic              AtMin,
  output logic              Wrapped,
  output logic              Blocked
);

  if (!params_ok(WIDTH, MAX_VAL, STEP_W)) begin : g_bad_params
    $error("step_counter_gen: illegal WIDTH/MAX_VAL/STEP_W combination");
  end

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic              b_en_q,      b_en_d;
  logic              b_mode_q,    b_mode_d;
  logic              b_wrap_q,    b_wrap_d;
  logic [STEP_W-1:0] b_step_q,    b_step_d;
  logic              b_load_q,    b_load_d;
  logic [WIDTH-1:0]  b_loadval_q, b_loadval_d;
  logic [WIDTH-1:0]  cnt_q,       cnt_d;
  logic              wrapped_q,   wrapped_d;
  logic              blocked_q,   blocked_d;

  logic [WIDTH-1:0]  nxt_cnt;
  logic              nxt_wrap;
  logic              nxt_block;

  step_counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP_W  (STEP_W)
  ) u_next (
    .cnt       (cnt_q),
    .b_mode    (b_mode_q),
    .b_wrap    (b_wrap_q),
    .b_step    (b_step_q),
    .nxt_cnt   (nxt_cnt),
    .nxt_wrap  (nxt_wrap),
    .nxt_block (nxt_block)
  );

  always_comb begin
    b_en_d      = En;
    b_mode_d    = Mode;
    b_wrap_d    = Wrap;
    b_step_d    = Step;
    b_load_d    = Load;
    b_loadval_d = LoadVal;
    cnt_d       = cnt_q;
    wrapped_d   = 1'b0;
    blocked_d   = 1'b0;
    if (b_load_q) begin
      cnt_d = (b_loadval_q > MAX_W) ? MAX_W : b_loadval_q;
    end else if (b_en_q) begin
      cnt_d     = nxt_cnt;
      wrapped_d = nxt_wrap;
      blocked_d = nxt_block;
    end
  end

  // Rst bypasses the input stage: it clears the count and the b_* copies together.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      b_en_q      <= '0;
      b_mode_q    <= '0;
      b_wrap_q    <= '0;
      b_step_q    <= '0;
      b_load_q    <= '0;
      b_loadval_q <= '0;
      cnt_q       <= '0;
      wrapped_q   <= '0;
      blocked_q   <= '0;
    end else begin
      b_en_q      <= b_en_d;
      b_mode_q    <= b_mode_d;
      b_wrap_q    <= b_wrap_d;
      b_step_q    <= b_step_d;
      b_load_q    <= b_load_d;
      b_loadval_q <= b_loadval_d;
      cnt_q       <= cnt_d;
      wrapped_q   <= wrapped_d;
      blocked_q   <= blocked_d;
    end
  end

  assign Cnt     = cnt_q;
  assign AtMax   = (cnt_q == MAX_W);
  assign AtMin   = (cnt_q == '0);
  assign Wrapped = wrapped_q;
  assign Blocked = blocked_q;

endmodule

// File: tb/tb_step_counter_gen.sv
// Scoreboard bench: two counter configurations driven in lockstep, checked against a behavioural model.
module tb_step_counter_gen;

  logic       clk = 1'b0;
  logic       rst, en, mode, wrap, load;
  logic [2:0] step_a;
  logic [3:0] lv_a;
  logic [3:0] step_b;
  logic [7:0] lv_b;

  logic [3:0] cnt_a;
  logic       at_max_a, at_min_a, wrapped_a, blocked_a;
  logic [7:0] cnt_b;
  logic       at_max_b, at_min_b, wrapped_b, blocked_b;

  always #5 clk = ~clk;

  step_counter_gen dut_a (
    .Clk(clk), .Rst(rst), .En(en), .Mode(mode), .Wrap(wrap), .Step(step_a),
    .Load(load), .LoadVal(lv_a), .Cnt(cnt_a), .AtMax(at_max_a), .AtMin(at_min_a),
    .Wrapped(wrapped_a), .Blocked(blocked_a)
  );

  step_counter_gen #(.WIDTH(8), .MAX_VAL(199), .STEP_W(4)) dut_b (
    .Clk(clk), .Rst(rst), .En(en), .Mode(mode), .Wrap(wrap), .Step(step_b),
    .Load(load), .LoadVal(lv_b), .Cnt(cnt_b), .AtMax(at_max_b), .AtMin(at_min_b),
    .Wrapped(wrapped_b), .Blocked(blocked_b)
  );

  typedef struct {
    bit en, mode, wrap, load;
    int step, lv;
  } cmd_t;

  typedef struct {
    int cnt_a, cnt_b;
    bit w_a, b_a, w_b, b_b;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  bit   running  = 1'b1;

  // Model state: the count and the command that will act on the next edge.
  int   m_cnt[2];
  cmd_t m_pend[2];
  int   maxv[2] = '{9, 199};

  task automatic apply(input cmd_t c, input int cnt, input int mx,
                       output int nc, output bit w, output bit b);
    nc = cnt; w = 0; b = 0;
    if (c.load) begin
      nc = (c.lv > mx) ? mx : c.lv;
    end else if (c.en) begin
      if (c.mode) begin
        if (cnt + c.step <= mx) nc = cnt + c.step;
        else if (c.wrap) begin nc = cnt + c.step - (mx + 1); w = 1; end
        else b = 1;
      end else begin
        if (cnt >= c.step) nc = cnt - c.step;
        else if (c.wrap) begin nc = cnt + (mx + 1) - c.step; w = 1; end
        else b = 1;
      end
    end
  endtask

  task automatic drive(input bit r, input bit e, input bit md, input bit wr,
                       input int st, input bit ld, input int lv);
    cmd_t c[2];
    int   nc[2];
    bit   w[2], b[2];
    exp_t x;
    rst = r; en = e; mode = md; wrap = wr; load = ld;
    step_a = 3'(st); lv_a = 4'(lv);
    step_b = 4'(st); lv_b = 8'(lv);
    c[0] = '{en: e, mode: md, wrap: wr, load: ld, step: st & 7,  lv: lv & 15};
    c[1] = '{en: e, mode: md, wrap: wr, load: ld, step: st & 15, lv: lv & 255};
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        nc[i] = 0; w[i] = 0; b[i] = 0;
        m_pend[i] = '{en: 0, mode: 0, wrap: 0, load: 0, step: 0, lv: 0};
      end else begin
        apply(m_pend[i], m_cnt[i], maxv[i], nc[i], w[i], b[i]);
        m_pend[i] = c[i];
      end
      m_cnt[i] = nc[i];
    end
    x.cnt_a = nc[0]; x.w_a = w[0]; x.b_a = b[0];
    x.cnt_b = nc[1]; x.w_b = w[1]; x.b_b = b[1];
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("cnt_a",     int'(cnt_a),     x.cnt_a);
      chk("at_max_a",  int'(at_max_a),  int'(x.cnt_a == 9));
      chk("at_min_a",  int'(at_min_a),  int'(x.cnt_a == 0));
      chk("wrapped_a", int'(wrapped_a), int'(x.w_a));
      chk("blocked_a", int'(blocked_a), int'(x.b_a));
      chk("cnt_b",     int'(cnt_b),     x.cnt_b);
      chk("at_max_b",  int'(at_max_b),  int'(x.cnt_b == 199));
      chk("at_min_b",  int'(at_min_b),  int'(x.cnt_b == 0));
      chk("wrapped_b", int'(wrapped_b), int'(x.w_b));
      chk("blocked_b", int'(blocked_b), int'(x.b_b));
    end else if (running) begin
      chk("scoreboard_empty", 0, 1);
    end
  end

  initial begin
    m_cnt = '{0, 0};
    m_pend[0] = '{en: 0, mode: 0, wrap: 0, load: 0, step: 0, lv: 0};
    m_pend[1] = m_pend[0];
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // Count up by one past the top with hold policy.
    for (int i = 0; i < 12; i++) drive(0, 1, 1, 0, 1, 0, 0);
    idle();
    // Overshoot hold vs exact reach.
    drive(0, 0, 0, 0, 0, 1, 7);
    drive(0, 1, 1, 0, 3, 0, 0);
    idle();
    drive(0, 0, 0, 0, 0, 1, 6);
    drive(0, 1, 1, 0, 3, 0, 0);
    idle();
    // Wrap up then wrap down.
    drive(0, 0, 0, 0, 0, 1, 8);
    drive(0, 1, 1, 1, 3, 0, 0);
    drive(0, 1, 0, 1, 2, 0, 0);
    idle();
    // Load clamp, then load beating enable.
    drive(0, 0, 0, 0, 0, 1, 15);
    idle();
    idle();
    drive(0, 1, 1, 0, 1, 1, 3);
    idle();
    // Reset overriding a pending load.
    drive(0, 0, 0, 0, 0, 1, 5);
    drive(0, 0, 0, 0, 0, 1, 2);
    drive(1, 0, 0, 0, 0, 1, 2);
    drive(0, 1, 1, 0, 1, 0, 0);
    idle();
    // Wide-configuration boundaries.
    drive(0, 0, 0, 0, 0, 1, 190);
    drive(0, 1, 1, 1, 15, 0, 0);
    idle();
    drive(0, 0, 0, 0, 0, 1, 10);
    drive(0, 1, 0, 0, 15, 0, 0);
    idle();
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
            1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 2), int'($urandom_range(0, 255)));
    end
    idle();
    idle();
    running = 1'b0;
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
